l1i_line_fill: RTL

//  Refill engine that sits directly downstream of the L1 instruction cache, on the MMU side.

---
 rtl/l1i_line_fill_if.sv | 20 ++
 rtl/l1i_line_fill.sv | 70 +++++++
 2 files changed

// File: rtl/l1i_line_fill_if.sv
// l1i_line_fill_if: L1I refill request/response and 32-bit memory port bundle for l1i_line_fill
interface l1i_line_fill_if;
   logic         l1_mmu_req_read;
   logic [31:0]  l1_mmu_req_addr;
   logic         mmu_l1_done;
   logic [255:0] mmu_l1_read_data;
   logic         mem_req;
   logic [31:0]  mem_addr;
   logic         mem_gnt;
   logic         mem_rvalid;
   logic [31:0]  mem_rdata;
   modport slave (
      input  l1_mmu_req_read, l1_mmu_req_addr, mem_gnt, mem_rvalid, mem_rdata,
      output mmu_l1_done, mmu_l1_read_data, mem_req, mem_addr
   );
   modport master (
      output l1_mmu_req_read, l1_mmu_req_addr, mem_gnt, mem_rvalid, mem_rdata,
      input  mmu_l1_done, mmu_l1_read_data, mem_req, mem_addr
   );
endinterface

// File: rtl/l1i_line_fill.sv
// l1i_line_fill: L1I 8-word line refill over a single-outstanding 32-bit port; L1I_FILL_MMIO_BYPASS_EN adds single-word MMIO reads
module l1i_line_fill #(
   parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
   parameter logic [31:0] MMIO_MASK = 32'hFFFF_0000
) (
   input logic            sys_clk,
   input logic            rst_n,
   l1i_line_fill_if.slave bus
);
`ifdef L1I_FILL_MMIO_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, COOL} state_t;
   state_t          state;
   logic [2:0]      cnt, last;
   logic [31:0]     base, mem_addr, start;
   logic [7:0][31:0] data;
   logic            mem_req, done, mmio;
   assign mmio  = BYPASS && ((bus.l1_mmu_req_addr & MMIO_MASK) == MMIO_BASE);
   assign start = mmio ? {bus.l1_mmu_req_addr[31:2], 2'b00} : {bus.l1_mmu_req_addr[31:5], 5'b0};
   assign bus.mem_req          = mem_req;
   assign bus.mem_addr         = mem_addr;
   assign bus.mmu_l1_done      = done;
   assign bus.mmu_l1_read_data = data;
   // One ISSUE/WAIT pair per word; the terminal word raises done for exactly the DONE cycle
   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= 3'd0;
         last     <= 3'd0;
         base     <= 32'd0;
         mem_req  <= 1'b0;
         mem_addr <= 32'd0;
         done     <= 1'b0;
         data     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: if (bus.l1_mmu_req_read) begin
               base     <= start;
               mem_addr <= start;
               last     <= mmio ? 3'd0 : 3'd7;
               cnt      <= 3'd0;
               mem_req  <= 1'b1;
               state    <= ISSUE;
            end
            ISSUE: if (bus.mem_gnt) begin
               mem_req <= 1'b0;
               state   <= WAIT;
            end
            WAIT: if (bus.mem_rvalid) begin
               data[cnt] <= bus.mem_rdata;
               if (cnt == last) begin
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  cnt      <= cnt + 3'd1;
                  mem_addr <= base + {27'd0, cnt + 3'd1, 2'b00};
                  mem_req  <= 1'b1;
                  state    <= ISSUE;
               end
            end
            DONE: state <= COOL;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
